event_encoder: RTL and testbench

Registered 8-to-3 priority encoder with event capture; it is the inverse of the 3-to-8 decoder. It detects rising edges on eight asynchronous request lines and latches each as a pending event. The highest-priority pending event is presented as a 3-bit index over a valid/ready handshake, and its pending bit clears when the index is accepted. It sits between raw push-button/flag inputs and a downstream consumer that works on encoded indices.

---
 rtl/event_encoder.sv | 102 ++++++++++
 tb/tb_event_encoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/event_encoder.sv
// Registered 8-to-3 priority encoder with edge-captured pending events.
// It presents one index at a time over a valid/ready handshake and pulses overflow when an event is lost.
module event_encoder #(
    parameter int unsigned PRIO_MSB = 1
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [7:0] in,
    input  logic       out_ready,
    output logic [2:0] out,
    output logic       out_valid,
    output logic       overflow
);

    typedef enum logic {
        IDLE,
        PRESENT
    } state_t;

    state_t     state;
    logic [7:0] in_d1;
    logic [7:0] in_d2;
    logic [7:0] in_d3;
    logic [7:0] pending;
    logic [7:0] rise;
    logic [7:0] accept_mask;
    logic       accept;

    function automatic logic [2:0] prio_enc(input logic [7:0] p);
        logic [2:0] idx;
        idx = '0;
        // The last match in the scan wins, so the scan direction sets the priority
        for (int unsigned i = 0; i < 8; i++) begin
            if (PRIO_MSB != 0) begin
                if (p[i]) idx = i[2:0];
            end else begin
                if (p[7-i]) idx = 3'(7 - i);
            end
        end
        return idx;
    endfunction

    assign rise   = in_d2 & ~in_d3;
    assign accept = (state == PRESENT) && out_valid && out_ready;

    always_comb begin
        accept_mask = '0;
        if (accept) accept_mask[out] = 1'b1;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            in_d1 <= '0;
            in_d2 <= '0;
            in_d3 <= '0;
        end else begin
            in_d1 <= in;
            in_d2 <= in_d1;
            in_d3 <= in_d2;
        end
    end

    // A rise coinciding with the accept of the same index keeps the bit set
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            pending  <= (pending & ~accept_mask) | rise;
            overflow <= |(rise & pending & ~accept_mask);
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state     <= IDLE;
            out       <= '0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pending != '0) begin
                        out       <= prio_enc(pending);
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_event_encoder.sv
// Self-checking bench for event_encoder: both priority orders side by side, checked
// each cycle against an event-level reference model, plus directed handshake scenarios.
module tb_event_encoder;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [7:0] in;
    logic       out_ready;
    logic [2:0] out0, out1;
    logic       out_valid0, out_valid1;
    logic       overflow0, overflow1;

    int n_checks;
    int n_fail;
    int cycle;

    // Reference model state: recent input samples and per-instance event bookkeeping
    logic [7:0] s1, s2, s3;
    logic [7:0] m_pend [2];
    logic       m_valid[2];
    int         m_cur  [2];
    logic       m_ovf  [2];

    int dq0[$];
    int dq1[$];
    int ovc[2];

    event_encoder #(.PRIO_MSB(1)) u_msb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in        (in),
        .out_ready (out_ready),
        .out       (out0),
        .out_valid (out_valid0),
        .overflow  (overflow0)
    );

    event_encoder #(.PRIO_MSB(0)) u_lsb (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .in        (in),
        .out_ready (out_ready),
        .out       (out1),
        .out_valid (out_valid1),
        .overflow  (overflow1)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s cycle=%0d got=%0d expected=%0d", tag, cycle, obs, exp);
        end
    endtask

    function automatic int pick(input logic [7:0] p, input bit msb_first);
        if (msb_first) begin
            for (int i = 7; i >= 0; i--) if (p[i]) return i;
        end else begin
            for (int i = 0; i < 8; i++) if (p[i]) return i;
        end
        return 0;
    endfunction

    task automatic model_reset();
        s1 = '0; s2 = '0; s3 = '0;
        for (int m = 0; m < 2; m++) begin
            m_pend[m]  = '0;
            m_valid[m] = 1'b0;
            m_cur[m]   = 0;
            m_ovf[m]   = 1'b0;
        end
    endtask

    // An event on line i is "seen high two samples ago, low three samples ago"
    task automatic model_edge();
        logic [7:0] rise;
        logic [7:0] clr;
        rise = s2 & ~s3;
        for (int m = 0; m < 2; m++) begin
            clr = '0;
            if (m_valid[m] && out_ready) clr[m_cur[m]] = 1'b1;
            m_ovf[m] = |(rise & m_pend[m] & ~clr);
            if (m_valid[m]) begin
                if (out_ready) m_valid[m] = 1'b0;
            end else if (m_pend[m] != 0) begin
                m_cur[m]   = pick(m_pend[m], m == 0);
                m_valid[m] = 1'b1;
            end
            m_pend[m] = (m_pend[m] & ~clr) | rise;
        end
        s3 = s2; s2 = s1; s1 = in;
    endtask

    task automatic step();
        if (out_valid0 && out_ready) dq0.push_back(int'(out0));
        if (out_valid1 && out_ready) dq1.push_back(int'(out1));
        @(posedge sys_clk);
        model_edge();
        #1;
        cycle++;
        if (overflow0) ovc[0]++;
        if (overflow1) ovc[1]++;
        check("valid_msb", out_valid0, m_valid[0]);
        check("out_msb",   out0,       m_cur[0]);
        check("ovf_msb",   overflow0,  m_ovf[0]);
        check("valid_lsb", out_valid1, m_valid[1]);
        check("out_lsb",   out1,       m_cur[1]);
        check("ovf_lsb",   overflow1,  m_ovf[1]);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clear_obs();
        dq0.delete();
        dq1.delete();
        ovc[0] = 0;
        ovc[1] = 0;
    endtask

    task automatic check_seq(input string tag, input int which, input int n,
                             input int e0, input int e1, input int e2);
        int q[$];
        int e[3];
        q = (which == 0) ? dq0 : dq1;
        e[0] = e0; e[1] = e1; e[2] = e2;
        check({tag, "_count"}, q.size(), n);
        for (int i = 0; i < n && i < q.size(); i++) check({tag, "_idx"}, q[i], e[i]);
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        cycle     = 0;
        sys_rst_n = 1'b0;
        in        = '0;
        out_ready = 1'b0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge sys_clk);
        #1;
        check("rst_valid", out_valid0, 0);
        check("rst_out",   out0,       0);
        check("rst_ovf",   overflow0,  0);
        check("rst_valid1", out_valid1, 0);
        sys_rst_n = 1'b1;

        // Single event on line 3
        clear_obs();
        out_ready = 1'b1;
        in = 8'h08; run(3);
        in = 8'h00; run(8);
        check_seq("single_msb", 0, 1, 3, 0, 0);
        check_seq("single_lsb", 1, 1, 3, 0, 0);
        check("single_ovf", ovc[0], 0);

        // Three simultaneous events, order depends on priority direction
        clear_obs();
        in = 8'h52; run(3);
        in = 8'h00; run(12);
        check_seq("prio_msb", 0, 3, 6, 4, 1);
        check_seq("prio_lsb", 1, 3, 1, 4, 6);

        // Backpressure: a later higher index must not preempt
        clear_obs();
        out_ready = 1'b0;
        in = 8'h04; run(5);
        in = 8'h84; run(8);
        check("bp_valid", out_valid0, 1);
        check("bp_out",   out0,       2);
        check("bp_out1",  out1,       2);
        out_ready = 1'b1;
        in = 8'h00; run(10);
        check_seq("bp_msb", 0, 2, 2, 7, 0);
        check_seq("bp_lsb", 1, 2, 2, 7, 0);

        // Overflow: second rise on line 5 while still pending
        clear_obs();
        out_ready = 1'b0;
        in = 8'h20; run(2);
        in = 8'h00; run(2);
        in = 8'h20; run(2);
        in = 8'h00; run(6);
        check("ovf_count", ovc[0], 1);
        check("ovf_count1", ovc[1], 1);
        out_ready = 1'b1;
        run(8);
        check_seq("ovf_msb", 0, 1, 5, 0, 0);

        // Rise on line 0 lands on the same edge as the accept of index 0
        clear_obs();
        out_ready = 1'b0;
        in = 8'h01; run(6);
        in = 8'h00; run(4);
        in = 8'h01; run(2);
        out_ready = 1'b1; run(1);
        in = 8'h00; run(6);
        check("setclr_ovf", ovc[0], 0);
        check_seq("setclr_msb", 0, 2, 0, 0, 0);

        // Asynchronous reset while an index is presented
        clear_obs();
        out_ready = 1'b0;
        in = 8'h10; run(5);
        check("prerst_valid", out_valid0, 1);
        in = 8'h00;
        sys_rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid0, 0);
        check("arst_out",   out0,       0);
        check("arst_valid1", out_valid1, 0);
        model_reset();
        #2;
        sys_rst_n = 1'b1;
        out_ready = 1'b1;
        run(6);
        check("postrst_valid", out_valid0, 0);

        // Randomized traffic with varying backpressure
        clear_obs();
        for (int c = 0; c < 3000; c++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) in[b] = ~in[b];
            out_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        in = 8'h00;
        out_ready = 1'b1;
        run(40);
        check("drain_valid", out_valid0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
